coin_input_cond: RTL and testbench

COIN_INPUT_COND -- requirements
Module: coin_input_cond

---
 rtl/coin_input_cond.sv | 141 ++++++++++++++
 tb/tb_coin_input_cond.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_input_cond.sv
// Coin/service input conditioning: two-flop sync, per-bit debounce, one-shot coin pulses
// and coin counter drive. Define COIN_COUNTER_STRETCH_EN to stretch counter drives to MIN_CNT cycles.
module coin_input_cond #(
  parameter int DB_CYCLES    = 16,
  parameter int PULSE_CYCLES = 64,
  parameter int MIN_CNT      = 128
) (
  input  logic       clk_main,
  input  logic       nreset,
  input  logic [3:0] P_coin_raw,
  input  logic [3:0] service_raw,
  input  logic [1:0] coin_counter_in,
  output logic [3:0] P_coin,
  output logic [3:0] service,
  output logic [1:0] coin_counter_drv
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int PW  = $clog2(PULSE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
  localparam logic [PW-1:0]  PULSE_LAST = PW'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_REL} coin_state_t;

  // Bits [3:0] are the coin switches, bits [7:4] the service switches.
  logic [7:0]     raw;
  logic [7:0]     sync1;
  logic [7:0]     sync2;
  logic [7:0]     deb;
  logic [DBW-1:0] db_cnt [8];
  coin_state_t    coin_state [4];
  logic [PW-1:0]  pulse_cnt [4];

  assign raw     = {service_raw, P_coin_raw};
  assign service = deb[7:4];

  if (DB_CYCLES < 1 || PULSE_CYCLES < 1 || MIN_CNT < 1) begin : g_bad_params
  end

  always_ff @(posedge clk_main or negedge nreset) begin
    if (!nreset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk_main or negedge nreset) begin
    if (!nreset) begin
      deb <= '1;
      for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // IDLE is only re-entered once the debounced level is high, so a low level seen
  // in IDLE is always a fresh 1->0 transition.
  always_ff @(posedge clk_main or negedge nreset) begin
    if (!nreset) begin
      P_coin <= '1;
      for (int i = 0; i < 4; i++) begin
        coin_state[i] <= IDLE;
        pulse_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        case (coin_state[i])
          IDLE: begin
            if (!deb[i]) begin
              coin_state[i] <= PULSE;
              pulse_cnt[i]  <= '0;
              P_coin[i]     <= 1'b0;
            end
          end
          PULSE: begin
            if (pulse_cnt[i] == PULSE_LAST) begin
              coin_state[i] <= WAIT_REL;
              P_coin[i]     <= 1'b1;
            end else begin
              pulse_cnt[i] <= pulse_cnt[i] + PW'(1);
            end
          end
          WAIT_REL: begin
            if (deb[i]) coin_state[i] <= IDLE;
          end
          default: begin
            coin_state[i] <= IDLE;
            P_coin[i]     <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef COIN_COUNTER_STRETCH_EN
  localparam int CW = $clog2(MIN_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MIN_CNT - 1);

  logic [1:0]    cnt_prev;
  logic [CW-1:0] stretch_cnt [2];

  // A rising edge loads the remaining hold time; the drive stays up while either
  // the hold time is running or the request is still high.
  always_ff @(posedge clk_main or negedge nreset) begin
    if (!nreset) begin
      coin_counter_drv <= '0;
      cnt_prev         <= '0;
      for (int i = 0; i < 2; i++) stretch_cnt[i] <= '0;
    end else begin
      cnt_prev <= coin_counter_in;
      for (int i = 0; i < 2; i++) begin
        if (coin_counter_in[i] && !cnt_prev[i]) begin
          stretch_cnt[i]      <= CNT_LAST;
          coin_counter_drv[i] <= 1'b1;
        end else begin
          coin_counter_drv[i] <= coin_counter_in[i] || (stretch_cnt[i] != '0);
          if (stretch_cnt[i] != '0) stretch_cnt[i] <= stretch_cnt[i] - CW'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge clk_main or negedge nreset) begin
    if (!nreset) coin_counter_drv <= '0;
    else         coin_counter_drv <= coin_counter_in;
  end
`endif

endmodule

// File: tb/tb_coin_input_cond.sv
// Bench for coin_input_cond: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the input conditioner.
module tb_coin_input_cond;

  localparam int DB    = 4;
  localparam int PULSE = 8;
  localparam int MINC  = 16;

  logic       clk;
  logic       nreset;
  logic [3:0] P_coin_raw;
  logic [3:0] service_raw;
  logic [1:0] coin_counter_in;
  logic [3:0] P_coin;
  logic [3:0] service;
  logic [1:0] coin_counter_drv;

  int n_pass;
  int n_total;

  coin_input_cond #(
    .DB_CYCLES(DB),
    .PULSE_CYCLES(PULSE),
    .MIN_CNT(MINC)
  ) dut (
    .clk_main(clk),
    .nreset(nreset),
    .P_coin_raw(P_coin_raw),
    .service_raw(service_raw),
    .coin_counter_in(coin_counter_in),
    .P_coin(P_coin),
    .service(service),
    .coin_counter_drv(coin_counter_drv)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] m_s1;
  logic [7:0] m_s2;
  logic [7:0] m_deb;
  int         m_run [8];
  bit         m_armed [4];
  int         m_remain [4];
  logic [3:0] m_pcoin;
  logic [1:0] m_drv;
  logic [1:0] m_prev;
  int         m_rise_t [2];
  int         cyc;

  task automatic model_reset();
    m_s1 = '1;
    m_s2 = '1;
    m_deb = '1;
    m_pcoin = '1;
    m_drv = '0;
    m_prev = '0;
    for (int i = 0; i < 8; i++) m_run[i] = 0;
    for (int i = 0; i < 4; i++) begin
      m_armed[i] = 1'b1;
      m_remain[i] = 0;
    end
    for (int i = 0; i < 2; i++) m_rise_t[i] = -1000000;
  endtask

  task automatic model_step();
    logic [7:0] raw;
    logic [7:0] deb_old;
    bit start;
    raw = {service_raw, P_coin_raw};
    deb_old = m_deb;
    cyc++;
    // one pulse of PULSE low cycles per press; re-armed only after a high level
    for (int i = 0; i < 4; i++) begin
      start = m_armed[i] && !deb_old[i];
      if (m_remain[i] > 0) m_remain[i]--;
      else if (!m_armed[i] && deb_old[i]) m_armed[i] = 1'b1;
      if (start) begin
        m_armed[i] = 1'b0;
        m_remain[i] = PULSE;
      end
      m_pcoin[i] = (m_remain[i] == 0);
    end
    // debounced level follows the synchronized input after DB consecutive disagreeing cycles
    for (int i = 0; i < 8; i++) begin
      if (m_s2[i] != deb_old[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_deb[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
    for (int i = 0; i < 2; i++) begin
      if (coin_counter_in[i] && !m_prev[i]) m_rise_t[i] = cyc;
      m_prev[i] = coin_counter_in[i];
`ifdef COIN_COUNTER_STRETCH_EN
      m_drv[i] = coin_counter_in[i] || (cyc - m_rise_t[i] < MINC);
`else
      m_drv[i] = coin_counter_in[i];
`endif
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    if (nreset) model_step();
    else model_reset();
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    nreset = 1'b0;
    P_coin_raw = 4'b0000;
    service_raw = 4'b0000;
    coin_counter_in = 2'b11;
    model_reset();
    settle(4);
    n_total++;
    if (P_coin !== 4'b1111) $display("FAIL reset_p_coin: got %b expected 1111", P_coin);
    else n_pass++;
    n_total++;
    if (service !== 4'b1111) $display("FAIL reset_service: got %b expected 1111", service);
    else n_pass++;
    n_total++;
    if (coin_counter_drv !== 2'b00) $display("FAIL reset_drv: got %b expected 00", coin_counter_drv);
    else n_pass++;
    P_coin_raw = 4'b1111;
    service_raw = 4'b1111;
    coin_counter_in = 2'b00;
    settle(2);
    nreset = 1'b1;
    settle(4);
  endtask

  task automatic test_single_press();
    int pulses;
    logic prev;
    logic expv;
    pulses = 0;
    prev = 1'b1;
    P_coin_raw[0] = 1'b0;
    for (int t = 1; t <= 100; t++) begin
      tick();
      expv = (t >= 7 && t <= 14) ? 1'b0 : 1'b1;
      n_total++;
      if (P_coin[0] !== expv) $display("FAIL single_press t=%0d: P_coin[0]=%b expected %b", t, P_coin[0], expv);
      else n_pass++;
      if (prev && !P_coin[0]) pulses++;
      prev = P_coin[0];
    end
    n_total++;
    if (pulses != 1) $display("FAIL single_press_count: got %0d pulses expected 1", pulses);
    else n_pass++;
    P_coin_raw[0] = 1'b1;
    settle(12);
    n_total++;
    if (P_coin !== 4'b1111) $display("FAIL single_press_release: P_coin=%b expected 1111", P_coin);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int lows;
    lows = 0;
    P_coin_raw[1] = 1'b0;
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (P_coin[1] !== 1'b1) lows++;
      if (t % 3 == 0) P_coin_raw[1] = ~P_coin_raw[1];
    end
    n_total++;
    if (lows != 0) $display("FAIL bounce: P_coin[1] low on %0d cycles expected 0", lows);
    else n_pass++;
    P_coin_raw[1] = 1'b1;
    settle(12);
  endtask

  task automatic test_simultaneous();
    logic [3:0] expv;
    P_coin_raw = 4'b0000;
    for (int t = 1; t <= 20; t++) begin
      tick();
      expv = (t >= 7 && t <= 14) ? 4'b0000 : 4'b1111;
      n_total++;
      if (P_coin !== expv) $display("FAIL simultaneous t=%0d: P_coin=%b expected %b", t, P_coin, expv);
      else n_pass++;
    end
    P_coin_raw = 4'b1111;
    settle(12);
  endtask

  task automatic test_service();
    logic [3:0] expv;
    service_raw[2] = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      expv = (t >= 6) ? 4'b1011 : 4'b1111;
      n_total++;
      if (service !== expv) $display("FAIL service_press t=%0d: service=%b expected %b", t, service, expv);
      else n_pass++;
    end
    service_raw[2] = 1'b1;
    for (int u = 1; u <= 10; u++) begin
      tick();
      expv = (u >= 6) ? 4'b1111 : 4'b1011;
      n_total++;
      if (service !== expv) $display("FAIL service_release u=%0d: service=%b expected %b", u, service, expv);
      else n_pass++;
    end
    n_total++;
    if (P_coin !== 4'b1111) $display("FAIL service_no_coin: P_coin=%b expected 1111", P_coin);
    else n_pass++;
  endtask

  task automatic test_reset_mid_pulse();
    logic expv;
    P_coin_raw[0] = 1'b0;
    settle(9);
    n_total++;
    if (P_coin[0] !== 1'b0) $display("FAIL mid_pulse_pre: P_coin[0]=%b expected 0", P_coin[0]);
    else n_pass++;
    nreset = 1'b0;
    #1;
    n_total++;
    if (P_coin !== 4'b1111) $display("FAIL mid_pulse_abort: P_coin=%b expected 1111", P_coin);
    else n_pass++;
    model_reset();
    @(negedge clk);
    tick();
    nreset = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      expv = (t >= 7 && t <= 14) ? 1'b0 : 1'b1;
      n_total++;
      if (P_coin[0] !== expv) $display("FAIL mid_pulse_repulse t=%0d: P_coin[0]=%b expected %b", t, P_coin[0], expv);
      else n_pass++;
    end
    P_coin_raw[0] = 1'b1;
    settle(12);
  endtask

  task automatic test_counter();
    int highs;
    logic expv;
    highs = 0;
    coin_counter_in[0] = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (t == 2) coin_counter_in[0] = 1'b0;
`ifdef COIN_COUNTER_STRETCH_EN
      expv = (t >= 1 && t <= MINC);
`else
      expv = (t >= 1 && t <= 2);
`endif
      n_total++;
      if (coin_counter_drv[0] !== expv) $display("FAIL counter t=%0d: drv[0]=%b expected %b", t, coin_counter_drv[0], expv);
      else n_pass++;
      n_total++;
      if (coin_counter_drv[1] !== 1'b0) $display("FAIL counter_other t=%0d: drv[1]=%b expected 0", t, coin_counter_drv[1]);
      else n_pass++;
      if (coin_counter_drv[0] === 1'b1) highs++;
    end
    n_total++;
`ifdef COIN_COUNTER_STRETCH_EN
    if (highs != MINC) $display("FAIL counter_width: high %0d cycles expected %0d", highs, MINC);
`else
    if (highs != 2) $display("FAIL counter_width: high %0d cycles expected 2", highs);
`endif
    else n_pass++;
  endtask

  task automatic test_random();
    int hold [10];
    for (int b = 0; b < 10; b++) hold[b] = $urandom_range(1, 10);
    for (int t = 0; t < 3000; t++) begin
      for (int b = 0; b < 8; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          if (b < 4) P_coin_raw[b] = $urandom_range(0, 1);
          else service_raw[b-4] = $urandom_range(0, 1);
          hold[b] = $urandom_range(1, 12);
        end
      end
      for (int b = 8; b < 10; b++) begin
        hold[b]--;
        if (hold[b] <= 0) begin
          coin_counter_in[b-8] = $urandom_range(0, 1);
          hold[b] = $urandom_range(1, 40);
        end
      end
      if (t == 1500) begin
        nreset = 1'b0;
        #1;
        model_reset();
        n_total++;
        if ({P_coin, service, coin_counter_drv} !== {4'b1111, 4'b1111, 2'b00})
          $display("FAIL random_reset: got %b expected 1111111100", {P_coin, service, coin_counter_drv});
        else n_pass++;
        tick();
        nreset = 1'b1;
      end
      tick();
      n_total++;
      if (P_coin !== m_pcoin) $display("FAIL random_p_coin t=%0d: got %b expected %b", t, P_coin, m_pcoin);
      else n_pass++;
      n_total++;
      if (service !== m_deb[7:4]) $display("FAIL random_service t=%0d: got %b expected %b", t, service, m_deb[7:4]);
      else n_pass++;
      n_total++;
      if (coin_counter_drv !== m_drv) $display("FAIL random_drv t=%0d: got %b expected %b", t, coin_counter_drv, m_drv);
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_pass = 0;
    n_total = 0;
    cyc = 0;
    nreset = 1'b0;
    P_coin_raw = 4'b1111;
    service_raw = 4'b1111;
    coin_counter_in = 2'b00;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_service();
    test_reset_mid_pulse();
    test_counter();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
